// File: rtl/codec_config_seq.sv
// codec_config_seq: after reset release (or a START pulse once the sequence
// has settled) it waits INIT_DELAY cycles, then writes a fixed table of
// audio-codec register commands through an external i2c writer. Each write
// uses a READY/GO/ACK handshake, and every handshake wait is bounded by
// TIMEOUT cycles. A timeout stops the sequence and holds ERROR.
//
// Ports:
//   CLK       system clock (shared with the i2c writer)
//   RST       asynchronous, active-high reset
//   START     re-runs the configuration when idle, done or in error
//   I2C_DATA  command word {reg_addr[6:0], reg_data[8:0]} to the writer
//   GO        transfer request to the writer
//   READY     writer idle and its last transfer complete
//   ACK       writer has accepted the command (pulse)
//   INDEX     table entry currently being written
//   DONE      all NUM_REGS entries written successfully (held)
//   ERROR     sequence aborted on a handshake timeout (held)
module codec_config_seq #(
  parameter int unsigned INIT_DELAY = 1000,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned NUM_REGS   = 11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic [15:0] I2C_DATA,
  output logic        GO,
  input  logic        READY,
  input  logic        ACK,
  output logic [3:0]  INDEX,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // Counters only need to reach their terminal value minus one; the timeout
  // counter is kept at least 2 bits wide so it can express the WAIT blanking.
  localparam int unsigned DW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
  localparam int unsigned TW = (TIMEOUT > 4) ? $clog2(TIMEOUT) : 2;

  localparam logic [DW-1:0] DLY_LAST = (INIT_DELAY > 1) ? DW'(INIT_DELAY - 1) : '0;
  localparam logic [TW-1:0] TO_LAST  = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] TO_BLANK = TW'(2);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_REGS - 1);

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    logic [15:0] word;
    case (idx)
      4'd0:    word = 16'h1E00;  // reset
      4'd1:    word = 16'h001A;
      4'd2:    word = 16'h021A;
      4'd3:    word = 16'h047B;
      4'd4:    word = 16'h067B;
      4'd5:    word = 16'h0812;  // line-in to ADC
      4'd6:    word = 16'h0A06;
      4'd7:    word = 16'h0C00;
      4'd8:    word = 16'h0E42;
      4'd9:    word = 16'h1002;
      4'd10:   word = 16'h1201;  // active
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

  state_t        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   data_q, data_d;

  logic to_expired;
  assign to_expired = (tcnt_q == TO_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_DELAY;
      dly_q   <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) begin
          state_d = S_DELAY;
          dly_d   = '0;
          tcnt_d  = '0;
          idx_d   = '0;
        end
      end

      S_DELAY: begin
        if (dly_q == DLY_LAST) begin
          state_d = S_LOAD;
          idx_d   = '0;
          tcnt_d  = '0;
          data_d  = table_entry(4'd0);
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end

      // READY takes priority over a coincident timeout.
      S_LOAD: begin
        if (READY) begin
          state_d = S_REQ;
          tcnt_d  = '0;
        end else if (to_expired) begin
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      // ACK takes priority over a coincident timeout.
      S_REQ: begin
        if (ACK) begin
          state_d = S_WAIT;
          tcnt_d  = '0;
        end else if (to_expired) begin
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      // The first two WAIT cycles still see the writer's pre-transfer READY,
      // so completion is only accepted once the counter has passed them.
      S_WAIT: begin
        if (READY && (tcnt_q >= TO_BLANK)) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            idx_d   = idx_q + 4'd1;
            tcnt_d  = '0;
            data_d  = table_entry(idx_q + 4'd1);
          end
        end else if (to_expired) begin
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: ;
    endcase
  end

  // GO decodes straight from the state register so an asynchronous reset
  // removes it without waiting for a clock edge.
  assign GO       = (state_q == S_REQ);
  assign DONE     = (state_q == S_DONE);
  assign ERROR    = (state_q == S_ERR);
  assign INDEX    = idx_q;
  assign I2C_DATA = data_q;

endmodule

// File: tb/tb_codec_config_seq.sv
// Bench for codec_config_seq. An i2c writer model answers GO with ACK after
// a random latency, keeps READY high for two stale cycles, then drops it and
// raises it again after a random latency. Every accepted command is logged and
// compared against the codec table. Handshake violations by the sequencer are
// counted. Directed scenarios cover the ACK timeout, a READY stuck low,
// ignored START, reset during a request, and the ACK/READY-versus-timeout ties.
module tb_codec_config_seq;

  localparam int unsigned INIT_DELAY = 10;
  localparam int unsigned TIMEOUT    = 40;
  localparam int unsigned NUM_REGS   = 11;
  localparam int          BUDGET     = INIT_DELAY + NUM_REGS * (3 * TIMEOUT + 3) + 20;

  localparam logic [15:0] EXP_TBL [11] = '{
    16'h1E00, 16'h001A, 16'h021A, 16'h047B, 16'h067B, 16'h0812,
    16'h0A06, 16'h0C00, 16'h0E42, 16'h1002, 16'h1201
  };

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] I2C_DATA;
  logic        GO;
  logic        READY;
  logic        ACK;
  logic [3:0]  INDEX;
  logic        DONE;
  logic        ERROR;

  codec_config_seq #(
    .INIT_DELAY(INIT_DELAY),
    .TIMEOUT   (TIMEOUT),
    .NUM_REGS  (NUM_REGS)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .I2C_DATA(I2C_DATA),
    .GO      (GO),
    .READY   (READY),
    .ACK     (ACK),
    .INDEX   (INDEX),
    .DONE    (DONE),
    .ERROR   (ERROR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Writer model configuration and log.
  bit          ack_en   = 1'b1;
  int          ack_min  = 1;
  int          ack_max  = 1;
  int          rdy_min  = 33;
  int          rdy_max  = 33;
  int          stuck_at = 0;
  int          wph      = 0;
  int          wcnt     = 0;
  int          wm       = 0;
  int          cur_ack  = 1;
  int          cur_rdy  = 4;
  int          proto_err = 0;
  logic [15:0] go_data;
  logic [15:0] acc_data [$];
  logic [3:0]  acc_idx  [$];

  // wph: 0 idle, 1 waiting to ACK, 2 busy after ACK, 4 never ACKs.
  initial begin
    ACK   = 1'b0;
    READY = 1'b1;
    forever begin
      @(negedge CLK);
      if (RST) begin
        ACK   = 1'b0;
        READY = 1'b1;
        wph   = 0;
      end else begin
        case (wph)
          0: begin
            ACK = 1'b0;
            if (GO) begin
              acc_data.push_back(I2C_DATA);
              acc_idx.push_back(INDEX);
              go_data = I2C_DATA;
              cur_ack = $urandom_range(ack_max, ack_min);
              cur_rdy = $urandom_range(rdy_max, rdy_min);
              wcnt    = 1;
              if (!ack_en) begin
                wph = 4;
              end else if (wcnt >= cur_ack) begin
                ACK = 1'b1;
                wm  = 0;
                wph = 2;
              end else begin
                wph = 1;
              end
            end
          end
          1: begin
            if (!GO || (I2C_DATA != go_data)) proto_err++;
            wcnt++;
            if (wcnt >= cur_ack) begin
              ACK = 1'b1;
              wm  = 0;
              wph = 2;
            end
          end
          2: begin
            ACK = 1'b0;
            wm++;
            if (GO) proto_err++;
            if (wm == 3) READY = 1'b0;
            if ((wm >= cur_rdy) && !((stuck_at != 0) && (acc_data.size() == stuck_at))) begin
              READY = 1'b1;
              wph   = 0;
            end
          end
          default: begin
            if (!GO) wph = 0;
          end
        endcase
      end
    end
  end

  int run_base   = 0;
  int proto_base = 0;
  bit inj5       = 1'b0;
  bit inj_done   = 1'b0;

  task automatic begin_run();
    run_base   = acc_data.size();
    proto_base = proto_err;
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_go", {31'b0, GO}, 0);
    check("rst_done", {31'b0, DONE}, 0);
    check("rst_error", {31'b0, ERROR}, 0);
    check("rst_index", {28'b0, INDEX}, 0);
    check("rst_data", {16'b0, I2C_DATA}, 0);
    begin_run();
    RST = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    begin_run();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check({tag, "_done_clr"}, {31'b0, DONE}, 0);
    check({tag, "_err_clr"}, {31'b0, ERROR}, 0);
    check({tag, "_idx_clr"}, {28'b0, INDEX}, 0);
  endtask

  task automatic measure_first_go(input string tag);
    int lat;
    lat = 0;
    while (!GO && (lat < int'(INIT_DELAY) + 10)) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, "_first_go"}, lat, INIT_DELAY + 1);
  endtask

  task automatic wait_end(input string tag, input bit noise);
    int cyc;
    cyc = 0;
    while (!(DONE || ERROR) && (cyc < BUDGET)) begin
      @(negedge CLK);
      cyc++;
      START = 1'b0;
      if (!DONE && !ERROR) begin
        if (noise && ($urandom_range(15, 0) == 0)) START = 1'b1;
        if (inj5 && !inj_done && ((acc_data.size() - run_base) == 6) && (wph == 2)) begin
          START    = 1'b1;
          inj_done = 1'b1;
        end
      end
    end
    START = 1'b0;
    check({tag, "_finished"}, {31'b0, DONE | ERROR}, 1);
  endtask

  task automatic check_done_run(input string tag);
    repeat (4) @(negedge CLK);
    check({tag, "_done"}, {31'b0, DONE}, 1);
    check({tag, "_error"}, {31'b0, ERROR}, 0);
    check({tag, "_index"}, {28'b0, INDEX}, NUM_REGS - 1);
    check({tag, "_go"}, {31'b0, GO}, 0);
    check({tag, "_writes"}, acc_data.size() - run_base, NUM_REGS);
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (run_base + i < acc_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), {16'b0, acc_data[run_base + i]}, {16'b0, EXP_TBL[i]});
        check($sformatf("%s_idx%0d", tag, i), {28'b0, acc_idx[run_base + i]}, i);
      end
    end
    check({tag, "_protocol"}, proto_err - proto_base, 0);
  endtask

  initial begin
    int cyc;
    int gohi;

    RST   = 1'b1;
    START = 1'b0;
    #7;
    check("por_go", {31'b0, GO}, 0);
    check("por_done", {31'b0, DONE}, 0);
    check("por_error", {31'b0, ERROR}, 0);
    check("por_index", {28'b0, INDEX}, 0);
    check("por_data", {16'b0, I2C_DATA}, 0);
    @(negedge CLK);

    // Nominal writer, START pulsed during WAIT of entry 5.
    ack_min = 1;  ack_max = 1;  rdy_min = 33; rdy_max = 33;
    inj5 = 1'b1;
    do_reset();
    measure_first_go("norm");
    wait_end("norm", 1'b0);
    check("norm_start_in_wait5", {31'b0, inj_done}, 1);
    check_done_run("norm");
    inj5 = 1'b0;

    // START after DONE, random writer latencies, random START noise.
    ack_min = 1;  ack_max = 4;  rdy_min = 4;  rdy_max = TIMEOUT;
    for (int r = 0; r < 4; r++) begin
      pulse_start($sformatf("rand%0d", r));
      measure_first_go($sformatf("rand%0d", r));
      wait_end($sformatf("rand%0d", r), 1'b1);
      check_done_run($sformatf("rand%0d", r));
    end

    // ACK and READY both arrive exactly at the timeout boundary.
    ack_min = TIMEOUT; ack_max = TIMEOUT; rdy_min = TIMEOUT; rdy_max = TIMEOUT;
    pulse_start("tie");
    measure_first_go("tie");
    wait_end("tie", 1'b0);
    check_done_run("tie");

    // ACK never arrives.
    ack_en = 1'b0;
    do_reset();
    measure_first_go("noack");
    cyc  = 0;
    gohi = 1;
    while (!ERROR && (cyc < int'(TIMEOUT) + 10)) begin
      @(negedge CLK);
      cyc++;
      if (GO) gohi++;
    end
    check("noack_err_time", cyc, TIMEOUT);
    check("noack_go_len", gohi, TIMEOUT);
    check("noack_error", {31'b0, ERROR}, 1);
    check("noack_index", {28'b0, INDEX}, 0);
    check("noack_go", {31'b0, GO}, 0);
    check("noack_done", {31'b0, DONE}, 0);
    repeat (5) @(negedge CLK);
    check("noack_err_held", {31'b0, ERROR}, 1);
    check("noack_idx_held", {28'b0, INDEX}, 0);

    // READY stuck low after the 4th ACK; restarted from ERR.
    ack_en  = 1'b1;
    ack_min = 1;  ack_max = 3;  rdy_min = 4;  rdy_max = 20;
    pulse_start("stuck");
    stuck_at = run_base + 4;
    measure_first_go("stuck");
    wait_end("stuck", 1'b1);
    check("stuck_error", {31'b0, ERROR}, 1);
    check("stuck_index", {28'b0, INDEX}, 3);
    check("stuck_done", {31'b0, DONE}, 0);
    check("stuck_go", {31'b0, GO}, 0);
    check("stuck_writes", acc_data.size() - run_base, 4);
    stuck_at = 0;

    // Reset while requesting entry 7; reset also clears the writer.
    ack_min = 6;  ack_max = 6;  rdy_min = 4;  rdy_max = TIMEOUT;
    do_reset();
    measure_first_go("rstmid");
    cyc = 0;
    while (!(GO && (INDEX == 4'd7)) && (cyc < BUDGET)) begin
      @(negedge CLK);
      cyc++;
    end
    check("rstmid_reached", {31'b0, GO && (INDEX == 4'd7)}, 1);
    #2 RST = 1'b1;
    #1;
    check("rstmid_go_async", {31'b0, GO}, 0);
    check("rstmid_idx_async", {28'b0, INDEX}, 0);
    check("rstmid_data_async", {16'b0, I2C_DATA}, 0);
    @(negedge CLK);
    do_reset();
    measure_first_go("rstmid_rerun");
    wait_end("rstmid_rerun", 1'b1);
    check_done_run("rstmid_rerun");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/codec_config_seq.md
CODEC_CONFIG_SEQ -- requirements
Module: codec_config_seq

Interface
REQ-001 The block SHALL have a parameter INIT_DELAY, default 1000, giving the clock cycles waited after reset release or START before the first write.
REQ-002 The block SHALL have a parameter TIMEOUT, default 255, giving the maximum cycles spent waiting for any single handshake event.
REQ-003 The block SHALL have a parameter NUM_REGS, default 11, giving the number of table entries written per run.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; the clock port SHALL be named CLK and the reset port RST.
REQ-005 Port CLK, input, 1 bit: system clock, which is the same clock that drives the i2c writer.
REQ-006 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port START, input, 1 bit: when high for one cycle in IDLE, DONE or ERR, it re-runs the full configuration.
REQ-008 Port I2C_DATA, output, 16 bits: the command word {reg_addr[6:0], reg_data[8:0]} to the i2c writer.
REQ-009 Port GO, output, 1 bit: the transfer request to the i2c writer.
REQ-010 Port READY, input, 1 bit: high when the i2c writer is idle and its last transfer is complete.
REQ-011 Port ACK, input, 1 bit: a pulse from the i2c writer meaning the command has been accepted.
REQ-012 Port INDEX, output, 4 bits: the table entry currently being written.
REQ-013 Port DONE, output, 1 bit: high while all NUM_REGS entries have been written successfully.
REQ-014 Port ERROR, output, 1 bit: high while the sequence is aborted on a timeout.

Function
REQ-015 The block SHALL contain a fixed table with these entries, in order:
- 0: 16'h1E00 (reset)
- 1: 16'h001A
- 2: 16'h021A
- 3: 16'h047B
- 4: 16'h067B
- 5: 16'h0812 (line-in to ADC)
- 6: 16'h0A06
- 7: 16'h0C00
- 8: 16'h0E42
- 9: 16'h1002
- 10: 16'h1201 (active)
REQ-016 The state machine SHALL have exactly these states: IDLE, DELAY, LOAD, REQ, WAIT, DONE and ERR.
REQ-017 DELAY SHALL count INIT_DELAY cycles and then go to LOAD with INDEX=0.
REQ-018 LOAD SHALL drive I2C_DATA from table[INDEX], wait for READY=1, and then go to REQ on the next cycle.
REQ-019 REQ SHALL hold GO=1 with I2C_DATA stable until ACK=1 is sampled, then clear GO the following cycle and go to WAIT.
REQ-020 WAIT SHALL wait for READY=1.
- If INDEX=NUM_REGS-1, it SHALL go to DONE.
- Otherwise it SHALL increment INDEX and go to LOAD.
REQ-021 WAIT SHALL ignore READY during the first 2 cycles after entry, so that the stale READY seen during the writer's state 0 is not taken as completion.
REQ-022 A single timeout counter SHALL be cleared on every entry to LOAD, REQ and WAIT and SHALL increment each cycle spent there.
- When it reaches TIMEOUT, the block SHALL go to ERR.
- In ERR, GO=0 and INDEX is frozen at the failing entry.
REQ-023 GO SHALL never be high outside REQ, and SHALL be high for at least 1 cycle and at most TIMEOUT cycles.
REQ-024 DONE and ERR SHALL be held until START or RST.
- START SHALL go to DELAY, clear DONE and ERROR, and set INDEX=0.
REQ-025 START SHALL be ignored in DELAY, LOAD, REQ and WAIT.
REQ-026 If ACK and the timeout expiry occur in the same cycle, ACK SHALL win and the block SHALL go to WAIT.
REQ-027 If READY and the timeout expiry occur in the same cycle in LOAD or WAIT, READY SHALL win.
REQ-028 The INDEX counter SHALL be 4 bits wide and SHALL never exceed NUM_REGS-1; no wrap-around is permitted.
REQ-029 Worst-case run time SHALL be INIT_DELAY + NUM_REGS*(3*TIMEOUT+3) cycles.

Reset
REQ-030 While RST=1, regardless of clock, the following SHALL hold:
- the state SHALL be DELAY
- GO=0, DONE=0, ERROR=0
- INDEX=0 and I2C_DATA=16'h0000
- the delay and timeout counters SHALL be 0
REQ-031 On release of RST, the configuration SHALL run automatically without START.
REQ-032 RST during a transfer SHALL drop GO in the same cycle; the bench SHALL also reset the i2c writer.

Verification
REQ-033 Normal run: INIT_DELAY=10, with a writer model returning ACK 1 cycle after GO and READY 33 cycles later.
- Required: 11 GO pulses.
- Required: the I2C_DATA sequence 1E00, 001A, 021A, 047B, 067B, 0812, 0A06, 0C00, 0E42, 1002, 1201.
- Required: DONE=1 and INDEX=10.
REQ-034 ACK held at 0: required ERROR=1 exactly TIMEOUT cycles after GO rises, with INDEX=0, GO=0 and DONE=0.
REQ-035 READY stuck at 0 after the 4th ACK: required ERROR=1 with INDEX=3.
REQ-036 START pulsed during WAIT of entry 5: required no effect, with the run completing with DONE=1 after 11 writes.
REQ-037 RST asserted mid-REQ at entry 7: required GO=0 asynchronously, then after release a fresh run from INDEX=0 that reaches DONE.
REQ-038 START after DONE: required DONE=0 on the next cycle, then a full 11-write run after INIT_DELAY.
